// File: rtl/muldiv_unit_if.sv
// Handshake bundle between the control unit and the multiply/divide unit.
// Master (issuer) drives request/flush/out_ready; slave returns ready/result/busy.
interface muldiv_unit_if #(
  parameter int W = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         flush;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         busy;

  modport master (
    output in_valid, op, a, b, flush, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  in_valid, op, a, b, flush, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV M-extension mul/div: one shift-add / restoring step per clock.
// Ports: clk, rst (sync, high), bus (muldiv_unit_if.slave). Option: MULDIV_EARLY_OUT_EN.
module muldiv_unit #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  muldiv_unit_if.slave bus
);
  localparam int CW = $clog2(W) + 1;

  typedef enum logic [1:0] {
    IDLE, CALC, FIX, DONE
  } state_t;

  state_t         state, state_n;
  logic [2:0]     op_q;
  logic [W-1:0]   a_q, b_q;
  logic [W-1:0]   mc;
  logic [2*W-1:0] acc;
  logic [W-1:0]   rem, quo;
  logic           neg_q;
  logic [CW-1:0]  cnt;
  logic [W-1:0]   res_q;

  logic           a_sgn, b_sgn, sa, sb, neg_d;
  logic [W-1:0]   ma, mb;
  logic           accept, early;

  logic [W:0]     sum;
  logic [2*W-1:0] mul_n;
  logic [W:0]     shl;
  logic [W-1:0]   diff;
  logic           ge;
  logic [2*W-1:0] prod;
  logic [W-1:0]   qv, rv, fix_res;

  function automatic logic is_ovf(
    input logic [2:0]   o,
    input logic [W-1:0] x,
    input logic [W-1:0] y
  );
    return (o == 3'b100 || o == 3'b110) &&
           x == {1'b1, {(W-1){1'b0}}} &&
           y == {W{1'b1}};
  endfunction

  // Result for zero-operand multiplies, divide by zero and signed overflow.
  function automatic logic [W-1:0] spec_res(
    input logic [2:0]   o,
    input logic [W-1:0] x,
    input logic [W-1:0] y
  );
    if (!o[2])
      return '0;
    if (y == '0)
      return o[1] ? x : {W{1'b1}};
    return o[1] ? '0 : x;
  endfunction

  always_comb begin
    a_sgn = 1'b0;
    b_sgn = 1'b0;
    unique case (1'b1)
      (bus.op == 3'b001),
      (bus.op == 3'b100),
      (bus.op == 3'b110): begin
        a_sgn = 1'b1;
        b_sgn = 1'b1;
      end
      (bus.op == 3'b010): a_sgn = 1'b1;
      default: ;
    endcase
    sa = a_sgn & bus.a[W-1];
    sb = b_sgn & bus.b[W-1];
    ma = sa ? -bus.a : bus.a;
    mb = sb ? -bus.b : bus.b;
    // Remainder takes the dividend's sign; everything else the xor.
    neg_d = (bus.op == 3'b110) ? sa : (sa ^ sb);
  end

  assign accept = (state == IDLE) && bus.in_valid && !bus.flush;

`ifdef MULDIV_EARLY_OUT_EN
  assign early = bus.op[2] ?
    (bus.b == '0 || is_ovf(bus.op, bus.a, bus.b)) :
    (bus.a == '0 || bus.b == '0);
`else
  assign early = 1'b0;
`endif

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (accept) state_n = early ? DONE : CALC;
      CALC: begin
        if (bus.flush)
          state_n = IDLE;
        else if (cnt == CW'(W - 1))
          state_n = FIX;
      end
      FIX:  state_n = bus.flush ? IDLE : DONE;
      DONE: if (bus.flush || bus.out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    sum   = {1'b0, acc[2*W-1:W]} + {1'b0, mc};
    mul_n = acc[0] ? {sum, acc[W-1:1]}
                   : {1'b0, acc[2*W-1:1]};
    shl   = {rem, quo[W-1]};
    ge    = shl >= {1'b0, mc};
    // Partial remainder stays below the divisor, so W bits hold the difference.
    diff  = shl[W-1:0] - mc;
    prod  = neg_q ? -acc : acc;
    qv    = neg_q ? -quo : quo;
    rv    = neg_q ? -rem : rem;
    fix_res = '0;
    if (op_q[2] && b_q == '0)
      fix_res = spec_res(op_q, a_q, b_q);
    else begin
      unique case (op_q)
        3'b000:                 fix_res = prod[W-1:0];
        3'b001, 3'b010, 3'b011: fix_res = prod[2*W-1:W];
        3'b100, 3'b101:         fix_res = qv;
        default:                fix_res = rv;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      mc    <= '0;
      acc   <= '0;
      rem   <= '0;
      quo   <= '0;
      neg_q <= 1'b0;
      cnt   <= '0;
      res_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            op_q  <= bus.op;
            a_q   <= bus.a;
            b_q   <= bus.b;
            neg_q <= neg_d;
            cnt   <= '0;
            // mc is the multiplicand for mul, the divisor for div.
            mc    <= bus.op[2] ? mb : ma;
            acc   <= {{W{1'b0}}, mb};
            rem   <= '0;
            quo   <= ma;
            if (early)
              res_q <= spec_res(bus.op, bus.a, bus.b);
          end
        end
        CALC: begin
          cnt <= cnt + 1'b1;
          if (op_q[2]) begin
            quo <= {quo[W-2:0], ge};
            rem <= ge ? diff : shl[W-1:0];
          end else begin
            acc <= mul_n;
          end
        end
        FIX: if (!bus.flush) res_q <= fix_res;
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state == CALC) || (state == FIX);
  assign bus.result    = res_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (W=32): vector table, random ops
// against a 64-bit arithmetic model, and backpressure/flush/reset sequences.
module tb_muldiv_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;

  muldiv_unit_if #(.W(32)) bus ();

  muldiv_unit #(.W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vt[15];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] op,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [63:0] sa, sb, ua, ub;
    logic [63:0] p;
    int ia, ib;
    logic ovf;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    ia = a;
    ib = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        return ia / ib;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic logic is_early(input logic [2:0] op,
                                    input logic [31:0] a,
                                    input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
    if (op >= 3'd4)
      return (b == 0) ||
             ((op == 3'd4 || op == 3'd6) &&
              a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    return (a == 0) || (b == 0);
`else
    return (op == 3'd0) && (a == 1) && (b == 1) && 1'b0;
`endif
  endfunction

  // Issue at posedge+1 with the unit in IDLE; returns result, edges after
  // accept until out_valid is seen, and cycles with busy high.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, output logic [31:0] res,
                        output int lat, output int bcnt);
    bus.op = op;
    bus.a = a;
    bus.b = b;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.a = $urandom;
    bus.b = $urandom;
    bus.op = 3'($urandom);
    lat = 0;
    bcnt = 0;
    while (!bus.out_valid && lat < 100) begin
      if (bus.busy) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
    res = bus.result;
  endtask

  task automatic retire(input logic [31:0] res);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("retire_out_valid", bus.out_valid, 0);
    chk("retire_in_ready", bus.in_ready, 1);
    chk("retire_result_kept", bus.result, res);
  endtask

  task automatic full_op(input string name, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b);
    logic [31:0] res;
    logic [31:0] e;
    int lat, bc, el;
    e = model(op, a, b);
    el = is_early(op, a, b) ? 0 : 33;
    run_op(op, a, b, res, lat, bc);
    chk({name, "_result"}, res, e);
    chk({name, "_latency"}, lat, el);
    chk({name, "_busy_cycles"}, bc, is_early(op, a, b) ? 0 : 33);
    retire(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] res, ra, rb;
    logic [2:0] rop;
    int lat, bc, seen;

    vt[0]  = '{3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB};
    vt[1]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
    vt[2]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vt[3]  = '{3'd2, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF};
    vt[4]  = '{3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD};
    vt[5]  = '{3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF};
    vt[6]  = '{3'd5, 32'd100,       32'd7,         32'd14};
    vt[7]  = '{3'd7, 32'd100,       32'd7,         32'd2};
    vt[8]  = '{3'd4, 32'd5,         32'd0,         32'hFFFF_FFFF};
    vt[9]  = '{3'd6, 32'd5,         32'd0,         32'd5};
    vt[10] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
    vt[11] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0};
    vt[12] = '{3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF};
    vt[13] = '{3'd7, 32'd5,         32'd0,         32'd5};
    vt[14] = '{3'd0, 32'd0,         32'd123,       32'd0};

    bus.in_valid = 1'b0;
    bus.op = 3'd0;
    bus.a = '0;
    bus.b = '0;
    bus.flush = 1'b0;
    bus.out_ready = 1'b0;

    @(posedge clk); @(posedge clk); #1;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_result", bus.result, 0);
    rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      run_op(vt[i].op, vt[i].a, vt[i].b, res, lat, bc);
      chk($sformatf("vec%0d_result", i), res, vt[i].exp);
      chk($sformatf("vec%0d_latency", i), lat,
          is_early(vt[i].op, vt[i].a, vt[i].b) ? 0 : 33);
      chk($sformatf("vec%0d_busy", i), bc,
          is_early(vt[i].op, vt[i].a, vt[i].b) ? 0 : 33);
      retire(vt[i].exp);
    end

    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 9))
        0: rb = 0;
        1: ra = 0;
        2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        3: rb = $urandom_range(1, 20);
        default: ;
      endcase
      full_op($sformatf("rnd%0d_op%0d", i, rop), rop, ra, rb);
    end

    // Backpressure: hold result in DONE, ignore a pulsed request.
    bus.op = 3'd5; bus.a = 32'd100; bus.b = 32'd7;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("bp_latency", lat, 33);
    for (int i = 0; i < 5; i++) begin
      chk("bp_out_valid", bus.out_valid, 1);
      chk("bp_result", bus.result, 14);
      chk("bp_in_ready", bus.in_ready, 0);
      if (i == 2) begin
        bus.op = 3'd0; bus.a = 32'd5; bus.b = 32'd5;
        bus.in_valid = 1'b1;
      end
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
    end
    // Retire with a simultaneous request: not taken on that edge.
    bus.op = 3'd0; bus.a = 32'd3; bus.b = 32'd3;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("bp_retire_out_valid", bus.out_valid, 0);
    chk("bp_retire_in_ready", bus.in_ready, 1);
    chk("bp_retire_busy", bus.busy, 0);
    run_op(3'd0, 32'd3, 32'd3, res, lat, bc);
    chk("bp_next_result", res, 9);
    chk("bp_next_latency", lat, 33);
    retire(32'd9);

    // Flush in the tenth CALC cycle.
    bus.op = 3'd3; bus.a = 32'hFFFF_FFFF; bus.b = 32'hFFFF_FFFF;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("fl_busy_before", bus.busy, 1);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    chk("fl_in_ready", bus.in_ready, 1);
    chk("fl_busy", bus.busy, 0);
    chk("fl_out_valid", bus.out_valid, 0);
    chk("fl_result_kept", bus.result, 9);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen++;
    end
    chk("fl_never_valid", seen, 0);

    // Flush wins over a request in IDLE.
    bus.op = 3'd5; bus.a = 32'd100; bus.b = 32'd7;
    bus.in_valid = 1'b1;
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.flush = 1'b0;
    chk("fl_idle_in_ready", bus.in_ready, 1);
    chk("fl_idle_busy", bus.busy, 0);
    full_op("fl_after_divu", 3'd5, 32'd100, 32'd7);

    // Reset in the middle of CALC.
    bus.op = 3'd0; bus.a = 32'd7; bus.b = 32'd3;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mrst_in_ready", bus.in_ready, 1);
    chk("mrst_out_valid", bus.out_valid, 0);
    chk("mrst_busy", bus.busy, 0);
    chk("mrst_result", bus.result, 0);
    rst = 1'b0;
    full_op("mrst_after_mul", 3'd0, 32'd7, 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
